// File: rtl/pipeline_subtractor_32bit.sv
// Byte-sliced pipelined subtractor: one lane per stage, borrow rippled through stage registers,
// results deskewed into a single output register behind a valid/ready handshake.
module pipeline_subtractor_32bit #(
    parameter int unsigned LANE_W = 8,
    parameter int unsigned LANES  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANE_W*LANES-1:0]   a,
    input  logic [LANE_W*LANES-1:0]   b,
    input  logic                      bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W*LANES-1:0]   diff,
    output logic                      bout,
    output logic                      ovf
);

    localparam int unsigned W = LANE_W * LANES;

    logic en;

    // Stage registers: operands delayed alongside the partially built difference.
    logic [W-1:0]   st_a  [LANES];
    logic [W-1:0]   st_b  [LANES];
    logic [W-1:0]   st_d  [LANES];
    logic           st_bo [LANES];
    logic           st_v  [LANES];

    // Stage inputs: stage 0 is fed from the ports, stage k from stage k-1.
    logic [W-1:0]   src_a  [LANES];
    logic [W-1:0]   src_b  [LANES];
    logic [W-1:0]   src_d  [LANES];
    logic           src_bi [LANES];
    logic           src_v  [LANES];

    logic [LANE_W:0] lane [LANES];
    logic [W-1:0]    nx_d [LANES];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        src_a[0]  = a;
        src_b[0]  = b;
        src_d[0]  = '0;
        src_bi[0] = bin;
        src_v[0]  = in_valid;
        for (int unsigned k = 1; k < LANES; k++) begin
            src_a[k]  = st_a[k-1];
            src_b[k]  = st_b[k-1];
            src_d[k]  = st_d[k-1];
            src_bi[k] = st_bo[k-1];
            src_v[k]  = st_v[k-1];
        end
    end

    // Each stage subtracts its own lane; bit LANE_W of the widened result is the borrow-out.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            lane[k] = {1'b0, src_a[k][k*LANE_W +: LANE_W]}
                    - {1'b0, src_b[k][k*LANE_W +: LANE_W]}
                    - (LANE_W+1)'(src_bi[k]);
            nx_d[k] = src_d[k];
            nx_d[k][k*LANE_W +: LANE_W] = lane[k][LANE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                st_a[k]  <= '0;
                st_b[k]  <= '0;
                st_d[k]  <= '0;
                st_bo[k] <= 1'b0;
                st_v[k]  <= 1'b0;
            end
        end else if (en) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                st_a[k]  <= src_a[k];
                st_b[k]  <= src_b[k];
                st_d[k]  <= nx_d[k];
                st_bo[k] <= lane[k][LANE_W];
                st_v[k]  <= src_v[k];
            end
        end
    end

    // Output register only reloads on a valid slot, so data persists once out_valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= st_v[LANES-1];
            if (st_v[LANES-1]) begin
                diff <= st_d[LANES-1];
                bout <= st_bo[LANES-1];
                ovf  <= (st_a[LANES-1][W-1] != st_b[LANES-1][W-1])
                     && (st_d[LANES-1][W-1] != st_a[LANES-1][W-1]);
            end
        end
    end

endmodule
